// File: rtl/wire_use_checker_pkg.sv
// Shared definitions for the wire_use response checker: FSM states, tap widths
// and the golden E function of the wire_use block.
package wire_use_checker_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_CHECK = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam int unsigned VEC_W = 3;          // {A,B,D}
    localparam int unsigned TAP_W = VEC_W + 1;  // {exp,A,B,D}

    function automatic logic golden(input logic a, input logic b, input logic d);
        return (a & b) | d;
    endfunction

endpackage

// File: rtl/wire_use_dly.sv
// WIDTH x DEPTH shift register with asynchronous reset; DEPTH=0 is a plain passthrough.
module wire_use_dly #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned DEPTH = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    generate
        if (DEPTH == 0) begin : g_pass
            logic w_unused_clk_rst;
            assign w_unused_clk_rst = clk_i | rst_i;
            assign q_o = d_i;
        end else begin : g_shift
            logic [WIDTH-1:0] r_line [DEPTH];

            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    for (int unsigned i = 0; i < DEPTH; i++) r_line[i] <= '0;
                end else begin
                    r_line[0] <= d_i;
                    for (int unsigned i = 1; i < DEPTH; i++) r_line[i] <= r_line[i-1];
                end
            end

            assign q_o = r_line[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/wire_use_checker.sv
// Response checker for wire_use: compares observed E against golden (A&B)|D delayed
// by DUT_LAT, counts vectors/mismatches and captures the first failing vector.
module wire_use_checker
    import wire_use_checker_pkg::*;
#(
    parameter int unsigned DUT_LAT = 1,
    parameter int unsigned CNT_W   = 16,
    parameter int unsigned N_VECS  = 7
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic             clr_i,
    input  logic             A_i,
    input  logic             B_i,
    input  logic             D_i,
    input  logic             E_i,
    output logic [CNT_W-1:0] vec_cnt_o,
    output logic [CNT_W-1:0] err_cnt_o,
    output logic             err_o,
    output logic [2:0]       first_err_vec_o,
    output logic [CNT_W-1:0] first_err_idx_o,
    output logic             busy_o,
    output logic             done_o
);

    localparam logic [2:0]       FILL_LAST = 3'(DUT_LAT - 1);
    localparam logic [CNT_W-1:0] LAST_IDX  = CNT_W'(N_VECS - 1);

    state_t             r_state, w_next;
    logic [2:0]         r_fill;
    logic [TAP_W-1:0]   w_tap_in, w_tap_out;
    logic               w_check, w_mismatch, w_last;
    logic [CNT_W-1:0]   r_vec_cnt, r_err_cnt, r_first_idx;
    logic [VEC_W-1:0]   r_first_vec;
    logic               r_err, r_done;

    assign w_tap_in = {golden(A_i, B_i, D_i), A_i, B_i, D_i};

    wire_use_dly #(
        .WIDTH (TAP_W),
        .DEPTH (DUT_LAT)
    ) u_dly (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .d_i   (w_tap_in),
        .q_o   (w_tap_out)
    );

    assign w_mismatch = (E_i !== w_tap_out[TAP_W-1]);
    // >= so a re-arm after a completed run (without clr) ends after one compare
    assign w_last     = (r_vec_cnt >= LAST_IDX);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) r_state <= ST_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        if (clr_i) begin
            w_next = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE:  if (en_i) w_next = (DUT_LAT == 0) ? ST_CHECK : ST_FILL;
                ST_FILL:  if (!en_i) w_next = ST_IDLE;
                          else if (r_fill == FILL_LAST) w_next = ST_CHECK;
                ST_CHECK: if (!en_i) w_next = ST_IDLE;
                          else if (w_last) w_next = ST_DONE;
                ST_DONE:  if (!en_i) w_next = ST_IDLE;
                default:  w_next = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        busy_o  = (r_state == ST_FILL) || (r_state == ST_CHECK);
        w_check = (r_state == ST_CHECK) && en_i && !clr_i;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_fill <= '0;
        end else if (!clr_i && en_i && (r_state == ST_FILL) && (r_fill != FILL_LAST)) begin
            r_fill <= r_fill + 3'd1;
        end else begin
            r_fill <= '0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i || clr_i) begin
            r_vec_cnt   <= '0;
            r_err_cnt   <= '0;
            r_first_idx <= '0;
            r_first_vec <= '0;
            r_err       <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done <= w_check && w_last;
            if (w_check) begin
                if (r_vec_cnt != '1) r_vec_cnt <= r_vec_cnt + CNT_W'(1);
                if (w_mismatch) begin
                    if (r_err_cnt != '1) r_err_cnt <= r_err_cnt + CNT_W'(1);
                    r_err <= 1'b1;
                    if (!r_err) begin
                        r_first_vec <= w_tap_out[VEC_W-1:0];
                        r_first_idx <= r_vec_cnt;
                    end
                end
            end
        end
    end

    assign vec_cnt_o       = r_vec_cnt;
    assign err_cnt_o       = r_err_cnt;
    assign err_o           = r_err;
    assign first_err_vec_o = r_first_vec;
    assign first_err_idx_o = r_first_idx;
    assign done_o          = r_done;

endmodule

// File: tb/tb_wire_use_checker.sv
// Randomized self-checking bench: three checker configurations against a run/cycle-level model.
`timescale 1ns/1ps
module tb_wire_use_checker;

    localparam int NI     = 3;
    localparam int M_IDLE = 0;
    localparam int M_RUN  = 1;
    localparam int M_DONE = 2;

    function automatic int lat_of(input int i);
        return (i == 0) ? 0 : (i == 1) ? 2 : 1;
    endfunction
    function automatic int wid_of(input int i);
        return (i == 2) ? 2 : 16;
    endfunction
    function automatic int nv_of(input int i);
        return (i == 2) ? 3 : 7;
    endfunction
    function automatic logic gold(input logic [2:0] v);
        return (v[2] & v[1]) | v[0];
    endfunction

    logic clk = 1'b0;
    logic rst, en, clr, a, b, d;
    logic e [NI];

    logic [15:0] u0_vec, u0_ec, u0_idx, u1_vec, u1_ec, u1_idx;
    logic [1:0]  u2_vec, u2_ec, u2_idx;
    logic [2:0]  u0_fv, u1_fv, u2_fv;
    logic        u0_err, u1_err, u2_err, u0_busy, u1_busy, u2_busy, u0_done, u1_done, u2_done;

    logic [15:0] o_vec [NI], o_ec [NI], o_idx [NI];
    logic [2:0]  o_fv [NI];
    logic        o_err [NI], o_busy [NI], o_done [NI];

    assign o_vec  = '{u0_vec, u1_vec, {14'd0, u2_vec}};
    assign o_ec   = '{u0_ec,  u1_ec,  {14'd0, u2_ec}};
    assign o_idx  = '{u0_idx, u1_idx, {14'd0, u2_idx}};
    assign o_fv   = '{u0_fv, u1_fv, u2_fv};
    assign o_err  = '{u0_err, u1_err, u2_err};
    assign o_busy = '{u0_busy, u1_busy, u2_busy};
    assign o_done = '{u0_done, u1_done, u2_done};

    always #5 clk = ~clk;

    wire_use_checker #(.DUT_LAT(0), .CNT_W(16), .N_VECS(7)) u0 (
        .clk_i(clk), .rst_i(rst), .en_i(en), .clr_i(clr), .A_i(a), .B_i(b), .D_i(d), .E_i(e[0]),
        .vec_cnt_o(u0_vec), .err_cnt_o(u0_ec), .err_o(u0_err), .first_err_vec_o(u0_fv),
        .first_err_idx_o(u0_idx), .busy_o(u0_busy), .done_o(u0_done));

    wire_use_checker #(.DUT_LAT(2), .CNT_W(16), .N_VECS(7)) u1 (
        .clk_i(clk), .rst_i(rst), .en_i(en), .clr_i(clr), .A_i(a), .B_i(b), .D_i(d), .E_i(e[1]),
        .vec_cnt_o(u1_vec), .err_cnt_o(u1_ec), .err_o(u1_err), .first_err_vec_o(u1_fv),
        .first_err_idx_o(u1_idx), .busy_o(u1_busy), .done_o(u1_done));

    wire_use_checker #(.DUT_LAT(1), .CNT_W(2), .N_VECS(3)) u2 (
        .clk_i(clk), .rst_i(rst), .en_i(en), .clr_i(clr), .A_i(a), .B_i(b), .D_i(d), .E_i(e[2]),
        .vec_cnt_o(u2_vec), .err_cnt_o(u2_ec), .err_o(u2_err), .first_err_vec_o(u2_fv),
        .first_err_idx_o(u2_idx), .busy_o(u2_busy), .done_o(u2_done));

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    task automatic chk(input string nm, input int i, input logic [15:0] act, input logic [15:0] want);
        n_chk++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s u%0d: got %0h, expected %0h (t=%0t)", nm, i, act, want, $time);
        end
    endtask

    // Reference model: a run starts the cycle after en is seen in idle; the first
    // lat cycles of a run only fill, every later cycle compares stimulus from lat cycles ago.
    logic [2:0]  hist [64];
    int          m_mode [NI], m_start [NI];
    logic [15:0] m_vec [NI], m_ec [NI], m_idx [NI];
    logic [2:0]  m_fv [NI];
    logic        m_err [NI], m_done [NI];

    task automatic model_reset();
        for (int j = 0; j < 64; j++) hist[j] = 3'd0;
        for (int i = 0; i < NI; i++) begin
            m_mode[i] = M_IDLE; m_start[i] = 0;
            m_vec[i] = 16'd0; m_ec[i] = 16'd0; m_idx[i] = 16'd0; m_fv[i] = 3'd0;
            m_err[i] = 1'b0; m_done[i] = 1'b0;
        end
    endtask

    task automatic model_step(input int i);
        logic [15:0] mx;
        logic [2:0]  v;
        int          lat;
        lat = lat_of(i);
        mx  = 16'((32'd1 << wid_of(i)) - 32'd1);
        m_done[i] = 1'b0;
        if (clr) begin
            m_mode[i] = M_IDLE;
            m_vec[i] = 16'd0; m_ec[i] = 16'd0; m_idx[i] = 16'd0; m_fv[i] = 3'd0; m_err[i] = 1'b0;
        end else if (m_mode[i] == M_IDLE) begin
            if (en) begin m_mode[i] = M_RUN; m_start[i] = cyc + 1; end
        end else if (m_mode[i] == M_RUN) begin
            if (!en) m_mode[i] = M_IDLE;
            else if (cyc >= m_start[i] + lat) begin
                v = hist[6'(cyc - lat)];
                if (e[i] !== gold(v)) begin
                    if (!m_err[i]) begin m_fv[i] = v; m_idx[i] = m_vec[i]; end
                    m_err[i] = 1'b1;
                    if (m_ec[i] < mx) m_ec[i] = m_ec[i] + 16'd1;
                end
                if (int'(m_vec[i]) >= nv_of(i) - 1) begin m_mode[i] = M_DONE; m_done[i] = 1'b1; end
                if (m_vec[i] < mx) m_vec[i] = m_vec[i] + 16'd1;
            end
        end else begin
            if (!en) m_mode[i] = M_IDLE;
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk);
            if (rst) model_reset();
            else begin
                hist[6'(cyc)] = {a, b, d};
                for (int i = 0; i < NI; i++) model_step(i);
            end
            cyc++;
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            for (int i = 0; i < NI; i++) begin
                chk("vec_cnt",   i, o_vec[i], m_vec[i]);
                chk("err_cnt",   i, o_ec[i],  m_ec[i]);
                chk("err",       i, 16'(o_err[i]),  16'(m_err[i]));
                chk("first_vec", i, 16'(o_fv[i]),   16'(m_fv[i]));
                chk("first_idx", i, o_idx[i], m_idx[i]);
                chk("busy",      i, 16'(o_busy[i]), 16'(m_mode[i] == M_RUN));
                chk("done",      i, 16'(o_done[i]), 16'(m_done[i]));
            end
        end
    end

    // Emulated wire_use responses: E = golden of stimulus dd cycles old, optionally inverted.
    logic [2:0] sh [8];
    int         dd [NI];
    int         done0;
    logic [2:0] vl [7];

    task automatic drive(input logic [2:0] v, input logic ven, input logic vclr, input logic [2:0] fl);
        @(negedge clk);
        if (o_done[0]) done0++;
        for (int j = 7; j > 0; j--) sh[j] = sh[j-1];
        sh[0] = v;
        {a, b, d} = v;
        en  = ven;
        clr = vclr;
        for (int i = 0; i < NI; i++) e[i] = gold(sh[3'(dd[i])]) ^ fl[i];
    endtask

    task automatic run_vl(input int first, input int last, input int fault_at);
        for (int k = first; k <= last; k++) drive(vl[k], 1'b1, 1'b0, (k == fault_at) ? 3'b001 : 3'b000);
    endtask

    task automatic chk_all_zero(input string nm);
        for (int i = 0; i < NI; i++) begin
            chk({nm, "_cnts"}, i, o_vec[i] | o_ec[i] | o_idx[i], 16'd0);
            chk({nm, "_flags"}, i, 16'({o_err[i], o_busy[i], o_done[i], o_fv[i]}), 16'd0);
        end
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; clr = 1'b0; a = 1'b0; b = 1'b0; d = 1'b0;
        for (int i = 0; i < NI; i++) e[i] = 1'b0;
        for (int j = 0; j < 8; j++) sh[j] = 3'd0;
        dd = '{0, 2, 1};
        done0 = 0;
        vl = '{3'b000, 3'b100, 3'b110, 3'b111, 3'b010, 3'b011, 3'b001};

        drive(3'd0, 1'b0, 1'b0, 3'd0);
        drive(3'd0, 1'b0, 1'b0, 3'd0);
        chk_all_zero("reset");
        rst = 1'b0;

        // Clean run of the seven reference vectors
        drive(3'd0, 1'b0, 1'b1, 3'd0);
        drive(3'd0, 1'b1, 1'b0, 3'd0);
        done0 = 0;
        run_vl(0, 6, -1);
        drive(3'd0, 1'b1, 1'b0, 3'd0);
        drive(3'd0, 1'b1, 1'b0, 3'd0);
        drive(3'd0, 1'b0, 1'b0, 3'd0);
        drive(3'd0, 1'b0, 1'b0, 3'd0);
        chk("t1_vec", 0, o_vec[0], 16'd7);
        chk("t1_model_vec", 0, m_vec[0], 16'd7);
        chk("t1_err_cnt", 0, o_ec[0], 16'd0);
        chk("t1_done_pulses", 0, 16'(done0), 16'd1);
        chk("t1_lat2_vec", 1, o_vec[1], 16'd7);
        chk("t1_lat2_err", 1, o_ec[1], 16'd0);

        // Wrong E on the fourth vector (111 -> 0)
        drive(3'd0, 1'b0, 1'b1, 3'd0);
        drive(3'd0, 1'b1, 1'b0, 3'd0);
        run_vl(0, 6, 3);
        drive(3'd0, 1'b0, 1'b0, 3'd0);
        drive(3'd0, 1'b0, 1'b0, 3'd0);
        chk("t2_err_cnt", 0, o_ec[0], 16'd1);
        chk("t2_err", 0, 16'(o_err[0]), 16'd1);
        chk("t2_first_vec", 0, 16'(o_fv[0]), 16'h7);
        chk("t2_model_first_vec", 0, 16'(m_fv[0]), 16'h7);
        chk("t2_first_idx", 0, o_idx[0], 16'd3);

        // Latency-2 checker against a DUT that is only one cycle late
        dd[1] = 1;
        drive(3'd0, 1'b0, 1'b1, 3'd0);
        drive(3'd0, 1'b1, 1'b0, 3'd0);
        run_vl(0, 6, -1);
        drive(3'd0, 1'b1, 1'b0, 3'd0);
        drive(3'd0, 1'b1, 1'b0, 3'd0);
        drive(3'd0, 1'b0, 1'b0, 3'd0);
        drive(3'd0, 1'b0, 1'b0, 3'd0);
        chk("t3_lat_err", 1, 16'(o_err[1]), 16'd1);
        dd[1] = 2;

        // en dropped after three vectors, then re-armed
        drive(3'd0, 1'b0, 1'b1, 3'd0);
        drive(3'd0, 1'b1, 1'b0, 3'd0);
        run_vl(0, 2, -1);
        drive(3'd0, 1'b0, 1'b0, 3'd0);
        drive(3'd0, 1'b0, 1'b0, 3'd0);
        chk("t4_hold_vec", 0, o_vec[0], 16'd3);
        chk("t4_hold_busy", 0, 16'(o_busy[0]), 16'd0);
        drive(3'd0, 1'b1, 1'b0, 3'd0);
        run_vl(3, 6, -1);
        drive(3'd0, 1'b1, 1'b0, 3'd0);
        drive(3'd0, 1'b0, 1'b0, 3'd0);
        chk("t4_end_vec", 0, o_vec[0], 16'd7);

        // clr beats en in the same cycle
        drive(3'd0, 1'b1, 1'b1, 3'd0);
        drive(3'd0, 1'b1, 1'b0, 3'd0);
        chk("t5_idle_busy", 0, 16'(o_busy[0]), 16'd0);
        chk("t5_idle_vec", 0, o_vec[0], 16'd0);
        drive(vl[0], 1'b1, 1'b0, 3'd0);
        chk("t5_start_busy", 0, 16'(o_busy[0]), 16'd1);
        drive(vl[1], 1'b1, 1'b0, 3'd0);
        chk("t5_first_cmp", 0, o_vec[0], 16'd1);
        drive(3'd0, 1'b0, 1'b0, 3'd0);

        // Narrow counters saturate under repeated failing runs
        drive(3'd0, 1'b0, 1'b1, 3'b100);
        for (int r = 0; r < 12; r++) begin
            drive(3'($urandom), 1'b1, 1'b0, 3'b100);
            for (int k = 0; k < 3; k++) drive(3'($urandom), 1'b1, 1'b0, 3'b100);
            drive(3'd0, 1'b0, 1'b0, 3'b100);
        end
        chk("t6_sat_err_cnt", 2, o_ec[2], 16'd3);
        chk("t6_sat_vec", 2, o_vec[2], 16'd3);

        // Asynchronous reset in the middle of a run
        drive(3'd0, 1'b1, 1'b0, 3'd0);
        drive(vl[1], 1'b1, 1'b0, 3'd0);
        drive(vl[2], 1'b1, 1'b0, 3'd0);
        #2 rst = 1'b1;
        #1 chk_all_zero("arst");
        drive(3'd0, 1'b0, 1'b0, 3'd0);
        drive(3'd0, 1'b0, 1'b0, 3'd0);
        rst = 1'b0;

        // Random traffic with occasional faults, clears, resets and en drops
        for (int n = 0; n < 3000; n++) begin
            logic [2:0] fl;
            for (int i = 0; i < NI; i++) fl[i] = ($urandom_range(0, 7) == 0);
            drive(3'($urandom), ($urandom_range(0, 11) != 0), ($urandom_range(0, 79) == 0), fl);
            if ($urandom_range(0, 499) == 0) begin
                rst = 1'b1;
                drive(3'($urandom), 1'b1, 1'b0, 3'd0);
                rst = 1'b0;
            end
        end
        drive(3'd0, 1'b0, 1'b0, 3'd0);
        drive(3'd0, 1'b0, 1'b0, 3'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
